corr_peak_collector: RTL and testbench
======================================

Name: corr_peak_collector

Overview:
Downstream consumer of the per-channel correlator blocks (ssc00..ssc31). It watches the cseen vector and picks flagged channels in round-robin order. For each one it becomes bus master and reads Cnt/Low/High/Status; the Status read clears the channel flag. It then forms the 64-bit correlation magnitude, tracks the running peak across channels, and emits one result record per event over a valid/ready interface toward the acquisition controller.

Parameters:
NCH, 32, number of correlator channels (cseen width)
CORR_BASE, 16'h07b0, address of channel 0 Correlation Cnt register
CH_STRIDE, 16'h0010, address step between channels
CHW, 5, channel index width, equal to clog2(NCH)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-low reset (rst==0 resets on the rising clk edge)
cseen  in  NCH  per-channel correlation-seen flags
bus_req  out  1  bus master request
bus_gnt  in  1  bus grant from host arbiter
addr  out  32  read address; upper 16 bits are 0
read  out  1  read strobe
Rdata  in  32  read data; combinational in the same cycle as read/addr
thresh  in  64  unsigned magnitude threshold
peak_clr  in  1  clears the peak registers
res_valid  out  1  result record valid
res_ready  in  1  consumer accepts the record
res_ch  out  CHW  channel index of the record
res_cnt  out  32  Correlation Cnt value
res_corr  out  64  signed correlation, {High,Low}
res_mag  out  64  unsigned |res_corr|
res_above  out  1  res_mag >= thresh
peak_mag  out  64  largest magnitude since reset or clear
peak_ch  out  CHW  channel holding the peak
evt_cnt  out  16  number of records accepted, saturating at 16'hffff

Behaviour:
- Reset (rst==0 at an edge): FSM goes to IDLE; rr_ptr=0; every output is 0, including bus_req, read, addr, res_valid, peak_*, evt_cnt. Reset mid-sequence abandons the sequence. The channel flag stays set and is serviced again after reset.
- cseen is registered once (cseen_q) before arbitration.
- The channel just serviced is masked for 2 cycles after RD_ST, which covers the flag-clear lag.
- Arbiter: picks the first set bit of cseen_q & ~mask, searching from rr_ptr upward with wrap. After RD_ST, rr_ptr becomes (ch+1) mod NCH.
- FSM states:
  - IDLE: if any eligible bit is set, latch ch and go to REQ.
  - REQ: bus_req=1. When bus_gnt=1, go to RD_CNT.
  - RD_CNT, RD_LO, RD_HI, RD_ST: one cycle each, with read=1 and addr=CORR_BASE+ch*CH_STRIDE+{0,4,8,C}. Rdata is captured at the end of each cycle. bus_req stays 1 through RD_ST, then drops.
  - EVAL: one cycle. corr={hi,lo}; mag = corr<0 ? -corr : corr, taken as unsigned 64-bit, so -2^63 gives 64'h8000_0000_0000_0000. Compute res_above. If mag>peak_mag (strict; ties keep the older entry), update peak_mag and peak_ch.
  - EMIT: res_valid=1 and fields held stable until res_ready=1. On that edge: res_valid drops, evt_cnt increments with saturation, go to IDLE.
- Addr changes every read cycle. The channel's status-clear condition (addr newly equal to +C) therefore fires exactly once per sequence.
- Grant loss: if bus_gnt drops in RD_CNT..RD_HI, drop read and return to REQ. The sequence restarts at RD_CNT (status is unread, so the flag is still pending). bus_gnt must not drop during RD_ST; the host arbiter guarantees this.
- Latency: from bus_gnt=1 sampled in REQ to res_valid=1 is 5 cycles (4 reads + EVAL).
- Back-to-back events: minimum spacing between records is 8 cycles with an immediate grant and res_ready=1.
- Backpressure: while in EMIT, new flags stay pending in the channels; no event is lost and no counters advance.
- peak_clr: peak_mag=0, peak_ch=0 on the next edge. If it coincides with an EVAL update, the EVAL update wins.
- Multiple flags in the same cycle: serviced in round-robin order, one full sequence each.

Decomposition:
- Package corr_pkg holds:
  - state enum (IDLE, REQ, RD_CNT, RD_LO, RD_HI, RD_ST, EVAL, EMIT);
  - register offsets OFF_CNT=0, OFF_LO=4, OFF_HI=8, OFF_ST=C;
  - a result record struct {ch, cnt, corr, mag, above}.
- Sub-module rr_arbiter (NCH-wide first-set-from-pointer finder, combinational, outputs idx and any). The FSM, datapath and peak logic stay in the top.

Test Plan:
- Single event: cseen[27]=1, bus_gnt tied 1, Rdata model returns Cnt=0x1F4, Low=0x0000_1000, High=0 → reads at 0x7b0+27*0x10+{0,4,8,C} in order. res_valid 5 cycles after grant with res_ch=27, res_cnt=0x1F4, res_mag=0x1000.
- Negative and extreme values: High=0xFFFF_FFFF, Low=0xFFFF_F000 → res_mag=0x1000. High=0x8000_0000, Low=0 → res_mag=64'h8000_0000_0000_0000. thresh=0x1000 → res_above=1 for both.
- Round-robin: cseen bits 3, 5 and 30 set together, rr_ptr=4 → service order 5, 30, 3. evt_cnt=3. peak_ch is the largest-magnitude channel; with equal magnitudes it stays 5.
- Backpressure and grant: res_ready=0 for 20 cycles → record held stable and cseen[7] pending is not serviced. bus_gnt drops in RD_LO → sequence restarts at RD_CNT and only one record is emitted.
- Reset mid-read: assert rst=0 in RD_HI → next edge shows all outputs 0. After release, the still-set flag is serviced fully.
- peak_clr: after peak 0x5000, pulse peak_clr → peak_mag=0. Next event with mag 0x10 → peak_mag=0x10.

Source files
------------

// File: rtl/corr_peak_collector_pkg.sv
// corr_pkg: shared types and constants for the correlation peak collector
//   NCH/CHW      channel count and channel index width
//   OFF_*        per-channel register offsets (Cnt, Low, High, Status)
//   state_t      collector FSM states
//   res_t        one result record {ch, cnt, corr, mag, above}
package corr_pkg;
    localparam int NCH = 32;
    localparam int CHW = $clog2(NCH);
    localparam logic [15:0] OFF_CNT = 16'h0;
    localparam logic [15:0] OFF_LO  = 16'h4;
    localparam logic [15:0] OFF_HI  = 16'h8;
    localparam logic [15:0] OFF_ST  = 16'hc;
    typedef enum logic [2:0] {IDLE, REQ, RD_CNT, RD_LO, RD_HI, RD_ST, EVAL, EMIT} state_t;
    typedef struct packed {
        logic [CHW-1:0] ch;
        logic [31:0]    cnt;
        logic [63:0]    corr;
        logic [63:0]    mag;
        logic           above;
    } res_t;
endpackage

// File: rtl/corr_peak_collector_if.sv
// corr_peak_collector_if: host bus master signals plus the result valid/ready channel
//   bus_req/bus_gnt   bus request and grant
//   addr/read/Rdata   read address, strobe and same-cycle read data
//   res_*             result record with valid/ready handshake
//   master modport: collector side; slave modport: host/consumer side
interface corr_peak_collector_if;
    import corr_pkg::*;
    logic           bus_req;
    logic           bus_gnt;
    logic [31:0]    addr;
    logic           read;
    logic [31:0]    Rdata;
    logic           res_valid;
    logic           res_ready;
    logic [CHW-1:0] res_ch;
    logic [31:0]    res_cnt;
    logic [63:0]    res_corr;
    logic [63:0]    res_mag;
    logic           res_above;
    modport master (
        output bus_req, addr, read, res_valid, res_ch, res_cnt, res_corr, res_mag, res_above,
        input  bus_gnt, Rdata, res_ready
    );
    modport slave (
        input  bus_req, addr, read, res_valid, res_ch, res_cnt, res_corr, res_mag, res_above,
        output bus_gnt, Rdata, res_ready
    );
endinterface

// File: rtl/corr_peak_collector_rr_arbiter.sv
// rr_arbiter: first set request bit searching upward from ptr with wrap
//   req  request vector
//   ptr  search start index
//   idx  index of the selected request (0 when none)
//   any  at least one request is set
module rr_arbiter #(
    parameter int NCH = 32,
    parameter int CHW = 5
) (
    input  logic [NCH-1:0] req,
    input  logic [CHW-1:0] ptr,
    output logic [CHW-1:0] idx,
    output logic           any
);
    // Scanning from the far end lets the nearest hit to ptr overwrite the rest.
    always_comb begin
        idx = '0;
        any = |req;
        for (int i = NCH - 1; i >= 0; i--)
            if (req[ptr + CHW'(i)]) idx = ptr + CHW'(i);
    end
endmodule

// File: rtl/corr_peak_collector.sv
// corr_peak_collector: services flagged correlator channels round-robin and reports magnitudes and peak
//   clk, rst     clock, synchronous active-low reset
//   cseen        per-channel correlation-seen flags
//   bus          master modport: bus request/grant, reads, result record handshake
//   thresh       magnitude threshold for res_above
//   peak_clr     clears the peak registers
//   peak_mag/ch  largest magnitude since reset or clear and its channel
//   evt_cnt      accepted records, saturating
module corr_peak_collector
    import corr_pkg::*;
#(
    parameter logic [15:0] CORR_BASE = 16'h07b0,
    parameter logic [15:0] CH_STRIDE = 16'h0010
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        cseen,
    corr_peak_collector_if.master bus,
    input  logic [63:0]           thresh,
    input  logic                  peak_clr,
    output logic [63:0]           peak_mag,
    output logic [CHW-1:0]        peak_ch,
    output logic [15:0]           evt_cnt
);
    state_t         state, state_n;
    logic [NCH-1:0] cseen_q, req;
    logic [CHW-1:0] ch, rr_ptr, arb_idx;
    logic           arb_any, rd;
    logic [1:0]     mask_cnt;
    logic [31:0]    cnt_q, lo_q, hi_q;
    logic [63:0]    corr, mag;
    logic [15:0]    off;
    res_t           res_q;

    rr_arbiter #(.NCH(NCH), .CHW(CHW)) u_arb (
        .req(req),
        .ptr(rr_ptr),
        .idx(arb_idx),
        .any(arb_any)
    );

    always_comb begin
        corr = {hi_q, lo_q};
        // Two's-complement negate; -2^63 wraps to itself, which is the correct unsigned magnitude.
        mag = corr[63] ? -corr : corr;
        // The channel just serviced is hidden while its flag clear propagates through cseen_q.
        req = cseen_q & ~(NCH'(mask_cnt != 2'd0) << ch);
        rd = state inside {RD_CNT, RD_LO, RD_HI, RD_ST};
        off = state == RD_LO ? OFF_LO : state == RD_HI ? OFF_HI : state == RD_ST ? OFF_ST : OFF_CNT;
        bus.bus_req = state == REQ || rd;
        // Grant is guaranteed held through RD_ST, so only the earlier reads are gated.
        bus.read = rd && (bus.bus_gnt || state == RD_ST);
        bus.addr = rd ? {16'h0, CORR_BASE + 16'(ch) * CH_STRIDE + off} : 32'h0;
        bus.res_valid = state == EMIT;
        bus.res_ch = res_q.ch;
        bus.res_cnt = res_q.cnt;
        bus.res_corr = res_q.corr;
        bus.res_mag = res_q.mag;
        bus.res_above = res_q.above;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = arb_any ? REQ : IDLE;
            REQ:     state_n = bus.bus_gnt ? RD_CNT : REQ;
            RD_CNT:  state_n = bus.bus_gnt ? RD_LO : REQ;
            RD_LO:   state_n = bus.bus_gnt ? RD_HI : REQ;
            RD_HI:   state_n = bus.bus_gnt ? RD_ST : REQ;
            RD_ST:   state_n = EVAL;
            EVAL:    state_n = EMIT;
            EMIT:    state_n = bus.res_ready ? IDLE : EMIT;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cseen_q  <= '0;
            ch       <= '0;
            rr_ptr   <= '0;
            mask_cnt <= '0;
            cnt_q    <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            res_q    <= '0;
            peak_mag <= '0;
            peak_ch  <= '0;
            evt_cnt  <= '0;
        end else begin
            state   <= state_n;
            cseen_q <= cseen;
            if (state == IDLE && arb_any) ch <= arb_idx;
            if (state == RD_CNT && bus.bus_gnt) cnt_q <= bus.Rdata;
            if (state == RD_LO && bus.bus_gnt) lo_q <= bus.Rdata;
            if (state == RD_HI && bus.bus_gnt) hi_q <= bus.Rdata;
            if (state == RD_ST) begin
                rr_ptr   <= ch + CHW'(1);
                mask_cnt <= 2'd2;
            end else if (mask_cnt != 2'd0) begin
                mask_cnt <= mask_cnt - 2'd1;
            end
            if (state == EVAL) res_q <= '{ch, cnt_q, corr, mag, mag >= thresh};
            if (state == EVAL && mag > peak_mag) begin
                peak_mag <= mag;
                peak_ch  <= ch;
            end else if (peak_clr) begin
                peak_mag <= '0;
                peak_ch  <= '0;
            end
            if (state == EMIT && bus.res_ready && evt_cnt != 16'hffff) evt_cnt <= evt_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_corr_peak_collector.sv
// tb_corr_peak_collector: directed bench for corr_peak_collector with a channel flag/register model
module tb_corr_peak_collector;
    import corr_pkg::*;
    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           peak_clr = 1'b0;
    logic [NCH-1:0] flags = '0;
    logic [NCH-1:0] set_mask = '0;
    logic [NCH-1:0] clr_vec;
    logic [63:0]    thresh = '0;
    logic [63:0]    peak_mag;
    logic [CHW-1:0] peak_ch;
    logic [15:0]    evt_cnt;
    logic [15:0]    rel;
    logic [31:0]    cnt_m [NCH];
    logic [31:0]    lo_m [NCH];
    logic [31:0]    hi_m [NCH];
    logic [31:0]    log_q [$];
    int             checks = 0;
    int             errors = 0;

    corr_peak_collector_if bus();

    corr_peak_collector dut (
        .clk(clk),
        .rst(rst),
        .cseen(flags),
        .bus(bus),
        .thresh(thresh),
        .peak_clr(peak_clr),
        .peak_mag(peak_mag),
        .peak_ch(peak_ch),
        .evt_cnt(evt_cnt)
    );

    always #5 clk = ~clk;

    // Channel register file: combinational read data; a Status read clears that channel's flag.
    always_comb begin
        rel = bus.addr[15:0] - 16'h07b0;
        bus.Rdata = rel[3:0] == 4'h0 ? cnt_m[rel[8:4]] :
                    rel[3:0] == 4'h4 ? lo_m[rel[8:4]] :
                    rel[3:0] == 4'h8 ? hi_m[rel[8:4]] : 32'h1;
        clr_vec = (bus.read && rel[3:0] == 4'hc) ? NCH'(1) << rel[8:4] : '0;
    end

    always @(posedge clk) begin
        flags <= (flags | set_mask) & ~clr_vec;
        if (bus.read) log_q.push_back(bus.addr);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic post(input logic [NCH-1:0] m);
        set_mask = m;
        @(negedge clk);
        set_mask = '0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!bus.res_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, " valid timeout"}, 64'(bus.res_valid), 64'd1);
    endtask

    task automatic wait_addr(input string tag, input logic [31:0] a);
        int n = 0;
        while (!(bus.read && bus.addr == a) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, " addr timeout"}, 64'(bus.read && bus.addr == a), 64'd1);
    endtask

    task automatic accept();
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int s;
        logic stable;
        for (int i = 0; i < NCH; i++) begin
            cnt_m[i] = '0;
            lo_m[i] = '0;
            hi_m[i] = '0;
        end
        cnt_m[27] = 32'h1f4; lo_m[27] = 32'h0000_1000; hi_m[27] = 32'h0;
        cnt_m[7]  = 32'h7;   lo_m[7]  = 32'hffff_f000; hi_m[7]  = 32'hffff_ffff;
        cnt_m[9]  = 32'h9;   lo_m[9]  = 32'h0;         hi_m[9]  = 32'h8000_0000;
        cnt_m[3]  = 32'h3;   lo_m[3]  = 32'h10;        hi_m[3]  = 32'h0;
        cnt_m[5]  = 32'h5;   lo_m[5]  = 32'h20;        hi_m[5]  = 32'h0;
        cnt_m[30] = 32'h1e;  lo_m[30] = 32'h20;        hi_m[30] = 32'h0;
        cnt_m[12] = 32'h77;  lo_m[12] = 32'h300;       hi_m[12] = 32'h0;
        cnt_m[20] = 32'h14;  lo_m[20] = 32'h40;        hi_m[20] = 32'h0;
        bus.bus_gnt = 1'b1;
        bus.res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset bus_req", 64'(bus.bus_req), 64'd0);
        check("reset read", 64'(bus.read), 64'd0);
        check("reset addr", 64'(bus.addr), 64'd0);
        check("reset res_valid", 64'(bus.res_valid), 64'd0);
        check("reset peak_mag", peak_mag, 64'd0);
        check("reset evt_cnt", 64'(evt_cnt), 64'd0);
        rst = 1'b1;

        thresh = 64'h1000;
        post(NCH'(1) << 27);
        n = 0;
        while (!bus.bus_req && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ch27 req seen", 64'(bus.bus_req), 64'd1);
        check("ch27 req no read", 64'(bus.read), 64'd0);
        @(negedge clk);
        check("ch27 rd_cnt addr", 64'(bus.addr), 64'h960);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.res_valid && n < 20);
        check("ch27 latency", 64'(n), 64'd5);
        check("ch27 res_ch", 64'(bus.res_ch), 64'd27);
        check("ch27 res_cnt", 64'(bus.res_cnt), 64'h1f4);
        check("ch27 res_corr", bus.res_corr, 64'h1000);
        check("ch27 res_mag", bus.res_mag, 64'h1000);
        check("ch27 res_above", 64'(bus.res_above), 64'd1);
        check("ch27 read count", 64'(log_q.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            check("ch27 read addr", 64'(log_q[i]), 64'h960 + 64'(4 * i));

        post(NCH'(1) << 7);
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            stable &= bus.res_valid && bus.res_ch == 5'd27 && bus.res_mag == 64'h1000 && !bus.bus_req;
        end
        check("backpressure hold", 64'(stable), 64'd1);
        check("backpressure evt_cnt", 64'(evt_cnt), 64'd0);
        accept();
        check("accept evt_cnt", 64'(evt_cnt), 64'd1);

        wait_valid("ch7");
        check("ch7 res_ch", 64'(bus.res_ch), 64'd7);
        check("ch7 res_corr", bus.res_corr, 64'hffff_ffff_ffff_f000);
        check("ch7 res_mag", bus.res_mag, 64'h1000);
        check("ch7 res_above", 64'(bus.res_above), 64'd1);
        check("tie peak_mag", peak_mag, 64'h1000);
        check("tie peak_ch", 64'(peak_ch), 64'd27);
        accept();
        check("ch7 evt_cnt", 64'(evt_cnt), 64'd2);

        post(NCH'(1) << 9);
        wait_valid("ch9");
        check("ch9 res_ch", 64'(bus.res_ch), 64'd9);
        check("ch9 res_mag", bus.res_mag, 64'h8000_0000_0000_0000);
        check("ch9 res_above", 64'(bus.res_above), 64'd1);
        check("ch9 peak_mag", peak_mag, 64'h8000_0000_0000_0000);
        check("ch9 peak_ch", 64'(peak_ch), 64'd9);
        accept();

        peak_clr = 1'b1;
        @(negedge clk);
        peak_clr = 1'b0;
        check("clr peak_mag", peak_mag, 64'd0);
        check("clr peak_ch", 64'(peak_ch), 64'd0);

        thresh = 64'h10;
        post(NCH'(1) << 3);
        wait_valid("ch3");
        check("ch3 res_mag", bus.res_mag, 64'h10);
        check("ch3 above at equal", 64'(bus.res_above), 64'd1);
        check("ch3 peak_mag", peak_mag, 64'h10);
        check("ch3 peak_ch", 64'(peak_ch), 64'd3);
        accept();

        thresh = 64'h11;
        post((NCH'(1) << 3) | (NCH'(1) << 5) | (NCH'(1) << 30));
        wait_valid("rr first");
        check("rr first ch", 64'(bus.res_ch), 64'd5);
        accept();
        wait_valid("rr second");
        check("rr second ch", 64'(bus.res_ch), 64'd30);
        accept();
        wait_valid("rr third");
        check("rr third ch", 64'(bus.res_ch), 64'd3);
        check("rr third below thresh", 64'(bus.res_above), 64'd0);
        accept();
        check("rr evt_cnt", 64'(evt_cnt), 64'd7);
        check("rr peak_mag", peak_mag, 64'h20);
        check("rr peak_ch", 64'(peak_ch), 64'd5);

        s = log_q.size();
        post(NCH'(1) << 12);
        wait_addr("gnt rd_lo", 32'h874);
        bus.bus_gnt = 1'b0;
        #1;
        check("gnt drop read", 64'(bus.read), 64'd0);
        @(negedge clk);
        check("gnt back to req", 64'({bus.bus_req, bus.read}), 64'b10);
        bus.bus_gnt = 1'b1;
        wait_valid("ch12");
        check("gnt read count", 64'(log_q.size() - s), 64'd5);
        check("gnt restart addr", 64'(log_q[s + 1]), 64'h870);
        check("gnt status addr", 64'(log_q[s + 4]), 64'h87c);
        check("ch12 res_mag", bus.res_mag, 64'h300);
        accept();
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            stable &= !bus.res_valid && !bus.bus_req;
        end
        check("gnt single record", 64'(stable), 64'd1);
        check("gnt evt_cnt", 64'(evt_cnt), 64'd8);
        check("gnt peak_ch", 64'(peak_ch), 64'd12);

        post(NCH'(1) << 20);
        wait_addr("rst rd_hi", 32'h8f8);
        rst = 1'b0;
        @(negedge clk);
        check("midrst bus_req", 64'(bus.bus_req), 64'd0);
        check("midrst read", 64'(bus.read), 64'd0);
        check("midrst addr", 64'(bus.addr), 64'd0);
        check("midrst res_valid", 64'(bus.res_valid), 64'd0);
        check("midrst res_mag", bus.res_mag, 64'd0);
        check("midrst peak_mag", peak_mag, 64'd0);
        check("midrst evt_cnt", 64'(evt_cnt), 64'd0);
        rst = 1'b1;
        wait_valid("ch20");
        check("ch20 res_ch", 64'(bus.res_ch), 64'd20);
        check("ch20 res_mag", bus.res_mag, 64'h40);
        accept();
        check("ch20 evt_cnt", 64'(evt_cnt), 64'd1);
        check("ch20 peak_mag", peak_mag, 64'h40);
        check("ch20 peak_ch", 64'(peak_ch), 64'd20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
